pipe_ctrl: RTL and testbench

Central pipeline control unit for the 5-stage core. Turns per-stage stall requests into the shared 6-bit stall vector (bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = STOP). It sequences exception/ERET flushes, holding a flush back while a MEM bus transaction is in flight. It also keeps a saturating stall-cycle performance counter and a stall watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipe_ctrl_sat.sv | 24 ++
 rtl/pipe_ctrl.sv | 96 +++++++++
 tb/tb_pipe_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: CtrlBus width, stall masks, FSM states.
package pipe_ctrl_pkg;

    localparam int          CTRL_W      = 6;            // CtrlBus: {WB,MEM,EX,ID,IF,PC}
    localparam logic        STOP        = 1'b1;
    localparam logic        NOSTOP      = 1'b0;
    localparam logic        RST_ENABLE  = 1'b1;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
    localparam logic [31:0] EXC_BASE_DEF = 32'h0000_0020;

    // Each mask stops the requesting stage and everything upstream of it.
    localparam logic [CTRL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [CTRL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [CTRL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [CTRL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [CTRL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        WAIT_MEM = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pipe_ctrl_sat.sv
// Saturating up-counter with synchronous clear; holds at MAX.
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    import pipe_ctrl_pkg::*;

    // Clear wins over increment; increment stops at MAX.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != MAX)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall priority encoder, exception/ERET flush sequencing
// (deferred while a MEM bus access is in flight), stall counter, watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] EXC_BASE = ADDR_W'(EXC_BASE_DEF),
    parameter int                TIMEOUT  = 1024,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              exc_req,
    input  logic              exc_eret,
    input  logic [ADDR_W-1:0] epc_i,
    output logic [CTRL_W-1:0] stall,
    output logic              flush,
    output logic [ADDR_W-1:0] new_pc,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              stall_timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    pc_state_t         state;
    logic [CTRL_W-1:0] enc;
    logic [WD_W-1:0]   wd_cnt;

    // Highest-priority stall request wins (deepest stage first).
    always_comb begin
        enc = STALL_NONE;
        if (stallreq_mem)     enc = STALL_MEM;
        else if (stallreq_ex) enc = STALL_EX;
        else if (stallreq_id) enc = STALL_ID;
        else if (stallreq_if) enc = STALL_IF;
    end

    // Flush decision; a flush overrides every stall, reset blanks everything.
    always_comb begin
        flush = NOSTOP;
        stall = enc;
        if (rst == RST_ENABLE) begin
            stall = STALL_NONE;
        end else begin
            unique case (state)
                RUN:      flush = exc_req && !stallreq_mem;
                WAIT_MEM: flush = !stallreq_mem;
                default:  flush = 1'b0;
            endcase
            if (flush) stall = STALL_NONE;
        end
        new_pc = flush ? (exc_eret ? epc_i : EXC_BASE) : '0;
    end

    // Hold an exception back in WAIT_MEM until the data bus goes idle.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN:      if (exc_req && stallreq_mem) state <= WAIT_MEM;
                WAIT_MEM: if (!stallreq_mem)           state <= RUN;
                default:  state <= RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W), .MAX('1)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall[0] == STOP),
        .clr (1'b0),
        .cnt (stall_cycles)
    );

    sat_counter #(.W(WD_W), .MAX(WD_W'(TIMEOUT))) u_wd_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall[0] == STOP),
        .clr (stall[0] == NOSTOP),
        .cnt (wd_cnt)
    );

    // Sticky watchdog flag: set on the edge that brings the run to TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE)
            stall_timeout <= 1'b0;
        else if (stall[0] == STOP && wd_cnt >= WD_W'(TIMEOUT - 1))
            stall_timeout <= 1'b1;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed test-plan sequences then random stimulus,
// all checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int TO   = 8;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic        clk;
    logic        rst, sif, sid, sex, smem, exc, eret;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [CW-1:0] stall_cycles;
    logic        stall_timeout;

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    bit m_pend;
    int m_cyc, m_wd;
    bit m_to;

    pipe_ctrl #(.ADDR_W(32), .EXC_BASE(32'h20), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (sif),
        .stallreq_id  (sid),
        .stallreq_ex  (sex),
        .stallreq_mem (smem),
        .exc_req      (exc),
        .exc_eret     (eret),
        .epc_i        (epc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cycles (stall_cycles),
        .stall_timeout(stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // One cycle: drive inputs, check outputs mid-cycle, advance model at edge.
    task automatic step(input logic r, i_f, i_d, e_x, m, x, er, input logic [31:0] pc);
        logic [5:0]  enc, es;
        logic        ef;
        logic [31:0] ep;
        rst = r; sif = i_f; sid = i_d; sex = e_x; smem = m; exc = x; eret = er; epc = pc;
        enc = m ? 6'h1f : e_x ? 6'h0f : i_d ? 6'h07 : i_f ? 6'h03 : 6'h00;
        ef  = !r && !m && (m_pend || x);
        es  = (r || ef) ? 6'h00 : enc;
        ep  = ef ? (er ? pc : 32'h20) : 32'h0;
        #2;
        chk("stall",        {26'b0, stall}, {26'b0, es});
        chk("flush",        {31'b0, flush}, {31'b0, ef});
        chk("new_pc",       new_pc, ep);
        chk("stall_cycles", {28'b0, stall_cycles}, m_cyc);
        chk("stall_timeout",{31'b0, stall_timeout}, {31'b0, m_to});
        @(posedge clk);
        if (r) begin
            m_pend = 0; m_cyc = 0; m_wd = 0; m_to = 0;
        end else begin
            m_pend = m_pend ? m : (x && m);
            if (es[0]) begin
                m_cyc = (m_cyc < CMAX) ? m_cyc + 1 : CMAX;
                m_wd  = (m_wd < TO) ? m_wd + 1 : TO;
            end else begin
                m_wd = 0;
            end
            if (m_wd >= TO) m_to = 1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        rst = 1; sif = 0; sid = 0; sex = 0; smem = 0; exc = 0; eret = 0; epc = 0;
        // settle registers before any checks
        @(posedge clk); #1;
        m_pend = 0; m_cyc = 0; m_wd = 0; m_to = 0;
        step(1, 1, 1, 1, 1, 1, 0, 32'h0);            // reset masks all inputs
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);

        // stall priority
        step(0, 1, 1, 0, 0, 0, 0, 32'h0);
        step(0, 1, 1, 1, 0, 0, 0, 32'h0);
        step(0, 1, 1, 1, 1, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0);

        // exception with idle bus overrides an EX stall
        step(0, 0, 0, 1, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0);

        // ERET deferred behind 3 bus-wait cycles, then one flush cycle
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 1, 32'h0000_1234);
        step(0, 0, 0, 0, 0, 1, 1, 32'h0000_1234);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0);

        // counter and watchdog
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 0, 0, 32'h0);
        idle(1);
        chk("cyc_after_10", {28'b0, stall_cycles}, 32'd10);
        chk("to_sticky",    {31'b0, stall_timeout}, 32'd1);

        // 7 stalled, 1 free, 7 stalled: watchdog must not trip
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 0, 0, 32'h0);
        idle(1);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 0, 0, 32'h0);
        idle(1);
        chk("to_not_tripped", {31'b0, stall_timeout}, 32'd0);

        // saturation at all-ones
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 0, 0, 32'h0);
        chk("cyc_saturated", {28'b0, stall_cycles}, 32'hF);

        // reset while WAIT_MEM with timeout set drops the pending flush
        step(0, 0, 0, 0, 1, 1, 0, 32'h0);
        step(0, 0, 0, 0, 1, 1, 0, 32'h0);
        step(1, 0, 0, 0, 1, 1, 0, 32'h0);
        chk("rst_cyc", {28'b0, stall_cycles}, 32'd0);
        chk("rst_to",  {31'b0, stall_timeout}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 0,
                 $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
